// File: rtl/pc_queue_f_pkg.sv
// Shared definitions for the PC generation queue: branch target-select
// encodings and the default boot address.
package pc_queue_f_pkg;

    typedef enum logic [1:0] {
        BRANCH_INDEX = 2'd0,
        BRANCH_REG   = 2'd1,
        BRANCH_IMM   = 2'd2,
        BRANCH_PC4   = 2'd3
    } br_sel_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'hbfc00000;

    // A branch leaves the sequential path only for INDEX, REG or a taken IMM.
    function automatic logic br_leaves_seq(input logic [1:0] sel, input logic taken);
        return (sel == BRANCH_INDEX) || (sel == BRANCH_REG) ||
               ((sel == BRANCH_IMM) && taken);
    endfunction

endpackage

// File: rtl/pc_queue_f_br_target_sel.sv
// Combinational branch target resolution; also reports whether the resolved
// target departs from the fall-through (pc+4) path.
module br_target_sel
    import pc_queue_f_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [1:0]    br_sel,
    input  logic          br_taken,
    input  logic [AW-1:0] br_pc4,
    input  logic [AW-1:0] br_imm,
    input  logic [AW-1:0] br_reg,
    input  logic [AW-1:0] br_index,
    output logic [AW-1:0] target,
    output logic          leaves_seq
);

    always_comb begin
        target = br_pc4;
        case (br_sel)
            BRANCH_INDEX: target = br_index;
            BRANCH_REG:   target = br_reg;
            BRANCH_IMM:   target = br_taken ? br_imm : br_pc4;
            default:      target = br_pc4;
        endcase
    end

    assign leaves_seq = br_leaves_seq(br_sel, br_taken);

endmodule

// File: rtl/pc_queue_f.sv
// PC generation queue: a small circular buffer filled with sequential PCs from
// gen_pc, drained by the downstream stage, restarted on flush or branch redirect.
module pc_queue_f
    import pc_queue_f_pkg::*;
#(
    parameter int            DEPTH    = 4,
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = AW'(DEFAULT_RESET_PC)
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       cur_stall,
    input  logic                       post_allowin,
    input  logic                       flush,
    input  logic [AW-1:0]              flush_pc,
    input  logic                       br_valid,
    input  logic [1:0]                 br_sel,
    input  logic                       br_taken,
    input  logic [AW-1:0]              br_pc4,
    input  logic [AW-1:0]              br_imm,
    input  logic [AW-1:0]              br_reg,
    input  logic [AW-1:0]              br_index,
    output logic                       out_valid,
    output logic [AW-1:0]              out_pc,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] gen_pc_q, gen_pc_d;

    logic [AW-1:0] br_target;
    logic          br_leaves;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          push;
    logic          pop;

    br_target_sel #(.AW(AW)) u_br_target_sel (
        .br_sel     (br_sel),
        .br_taken   (br_taken),
        .br_pc4     (br_pc4),
        .br_imm     (br_imm),
        .br_reg     (br_reg),
        .br_index   (br_index),
        .target     (br_target),
        .leaves_seq (br_leaves)
    );

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    // Flush outranks any branch presented in the same cycle.
    assign redirect    = flush || (br_valid && br_leaves);
    assign redirect_pc = flush ? flush_pc : br_target;

    assign full      = (count_q == CW'(DEPTH));
    assign out_valid = (count_q != '0) && !cur_stall;
    assign out_pc    = mem_q[rd_ptr_q];
    assign count     = count_q;

    assign pop  = out_valid && post_allowin && !redirect;
    assign push = !redirect && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        gen_pc_d = gen_pc_q;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            gen_pc_d = redirect_pc;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
                gen_pc_d = gen_pc_q + AW'(4);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            gen_pc_q <= RESET_PC;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            gen_pc_q <= gen_pc_d;
        end
    end

    // Entry storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= gen_pc_q;
        end
    end

endmodule

// File: tb/tb_pc_queue_f.sv
// Directed bench for pc_queue_f: a vector table for single-cycle behaviour and
// hand-written sequences for stall saturation and asynchronous reset.
module tb_pc_queue_f;
    import pc_queue_f_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cur_stall, post_allowin, flush;
    logic [31:0] flush_pc;
    logic        br_valid;
    logic [1:0]  br_sel;
    logic        br_taken;
    logic [31:0] br_pc4, br_imm, br_reg, br_index;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [2:0]  count;
    logic        full;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_queue_f dut (
        .clk          (clk),
        .resetn       (resetn),
        .cur_stall    (cur_stall),
        .post_allowin (post_allowin),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .br_valid     (br_valid),
        .br_sel       (br_sel),
        .br_taken     (br_taken),
        .br_pc4       (br_pc4),
        .br_imm       (br_imm),
        .br_reg       (br_reg),
        .br_index     (br_index),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .count        (count),
        .full         (full)
    );

    typedef struct {
        logic        stall;
        logic        allow;
        logic        fl;
        logic [31:0] fpc;
        logic        bv;
        logic [1:0]  sel;
        logic        tk;
        logic [31:0] tgt;
        logic        e_valid;
        logic        chk_pc;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
        logic        e_full;
    } vec_t;

    vec_t v[30];

    function automatic vec_t mk(input logic stall, input logic allow,
                                input logic fl, input logic [31:0] fpc,
                                input logic bv, input logic [1:0] sel,
                                input logic tk, input logic [31:0] tgt,
                                input logic e_valid, input logic chk_pc,
                                input logic [31:0] e_pc, input logic [2:0] e_cnt,
                                input logic e_full);
        vec_t r;
        r.stall = stall; r.allow = allow; r.fl = fl; r.fpc = fpc;
        r.bv = bv; r.sel = sel; r.tk = tk; r.tgt = tgt;
        r.e_valid = e_valid; r.chk_pc = chk_pc; r.e_pc = e_pc;
        r.e_cnt = e_cnt; r.e_full = e_full;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush    = 1'b0;
        flush_pc = 32'h0;
        br_valid = 1'b0;
        br_sel   = BRANCH_PC4;
        br_taken = 1'b0;
        br_pc4   = 32'h0000_0444;
        br_imm   = 32'h0000_0eee;
        br_reg   = 32'h0000_0aaa;
        br_index = 32'h0000_0ddd;
    endtask

    localparam logic [1:0] SI = BRANCH_INDEX;
    localparam logic [1:0] SR = BRANCH_REG;
    localparam logic [1:0] SM = BRANCH_IMM;
    localparam logic [1:0] SP = BRANCH_PC4;

    initial begin
        // stall allow fl fpc bv sel tk tgt | valid chkpc pc cnt full
        v[0]  = mk(0,0,1,32'hbfc00000,0,SP,0,0, 0,0,32'h0,0,0);
        v[1]  = mk(0,0,0,0,0,SP,0,0, 1,1,32'hbfc00000,1,0);
        v[2]  = mk(0,0,0,0,0,SP,0,0, 1,1,32'hbfc00000,2,0);
        v[3]  = mk(0,0,0,0,0,SP,0,0, 1,1,32'hbfc00000,3,0);
        v[4]  = mk(0,0,0,0,0,SP,0,0, 1,1,32'hbfc00000,4,1);
        v[5]  = mk(0,0,0,0,0,SP,0,0, 1,1,32'hbfc00000,4,1);
        v[6]  = mk(0,1,0,0,0,SP,0,0, 1,1,32'hbfc00004,4,1);
        v[7]  = mk(0,1,0,0,0,SP,0,0, 1,1,32'hbfc00008,4,1);
        v[8]  = mk(0,1,0,0,1,SM,0,32'h5555_0000, 1,1,32'hbfc0000c,4,1);
        v[9]  = mk(0,1,0,0,1,SP,1,32'h6666_0000, 1,1,32'hbfc00010,4,1);
        v[10] = mk(1,1,0,0,0,SP,0,0, 0,1,32'hbfc00010,4,1);
        v[11] = mk(0,1,0,0,1,SM,1,32'h80001000, 0,0,32'h0,0,0);
        v[12] = mk(0,1,0,0,0,SP,0,0, 1,1,32'h80001000,1,0);
        v[13] = mk(0,0,0,0,0,SP,0,0, 1,1,32'h80001000,2,0);
        v[14] = mk(0,0,0,0,0,SP,0,0, 1,1,32'h80001000,3,0);
        v[15] = mk(0,1,0,0,1,SM,1,32'h80001000, 0,0,32'h0,0,0);
        v[16] = mk(0,0,0,0,0,SP,0,0, 1,1,32'h80001000,1,0);
        v[17] = mk(0,0,0,0,0,SP,0,0, 1,1,32'h80001000,2,0);
        v[18] = mk(0,1,0,0,0,SP,0,0, 1,1,32'h80001004,2,0);
        v[19] = mk(0,1,1,32'hbfc00380,1,SR,0,32'h00001234, 0,0,32'h0,0,0);
        v[20] = mk(0,1,0,0,0,SP,0,0, 1,1,32'hbfc00380,1,0);
        v[21] = mk(0,1,0,0,0,SP,0,0, 1,1,32'hbfc00384,1,0);
        v[22] = mk(0,1,0,0,1,SR,0,32'h00001234, 0,0,32'h0,0,0);
        v[23] = mk(0,1,0,0,0,SP,0,0, 1,1,32'h00001234,1,0);
        v[24] = mk(0,1,0,0,1,SI,0,32'h00002000, 0,0,32'h0,0,0);
        v[25] = mk(0,0,0,0,0,SP,0,0, 1,1,32'h00002000,1,0);
        v[26] = mk(0,0,1,32'hfffffffc,0,SP,0,0, 0,0,32'h0,0,0);
        v[27] = mk(0,0,0,0,0,SP,0,0, 1,1,32'hfffffffc,1,0);
        v[28] = mk(0,0,0,0,0,SP,0,0, 1,1,32'hfffffffc,2,0);
        v[29] = mk(0,1,0,0,0,SP,0,0, 1,1,32'h00000000,2,0);

        idle_inputs();
        cur_stall    = 1'b0;
        post_allowin = 1'b1;
        resetn       = 1'b0;
        repeat (2) step();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_full", 32'(full), 32'd0);

        // Boot stream from RESET_PC.
        resetn = 1'b1;
        chk("boot_pre_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("boot_valid", 32'(out_valid), 32'd1);
            chk("boot_pc", out_pc, 32'hbfc00000 + 32'(4 * k));
        end

        for (int i = 0; i < 30; i++) begin
            idle_inputs();
            cur_stall    = v[i].stall;
            post_allowin = v[i].allow;
            flush        = v[i].fl;
            flush_pc     = v[i].fpc;
            br_valid     = v[i].bv;
            br_sel       = v[i].sel;
            br_taken     = v[i].tk;
            case (v[i].sel)
                SI: br_index = v[i].tgt;
                SR: br_reg   = v[i].tgt;
                SM: br_imm   = v[i].tgt;
                default: br_pc4 = v[i].tgt;
            endcase
            step();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(v[i].e_valid));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(v[i].e_cnt));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(v[i].e_full));
            if (v[i].chk_pc) chk($sformatf("vec%0d_pc", i), out_pc, v[i].e_pc);
        end

        // Stall saturation, then in-order drain.
        idle_inputs();
        flush = 1'b1; flush_pc = 32'hbfc00100;
        cur_stall = 1'b1; post_allowin = 1'b1;
        step();
        chk("stall_flush_count", 32'(count), 32'd0);
        flush = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("stall_valid", 32'(out_valid), 32'd0);
            chk("stall_count", 32'(count), (k < 4) ? 32'(k) : 32'd4);
        end
        chk("stall_full", 32'(full), 32'd1);
        cur_stall = 1'b0;
        #1;
        chk("drain_valid", 32'(out_valid), 32'd1);
        chk("drain_pc0", out_pc, 32'hbfc00100);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("drain_pc", out_pc, 32'hbfc00100 + 32'(4 * k));
            chk("drain_count", 32'(count), 32'd4);
        end

        // Asynchronous reset mid-stream with two entries held.
        flush = 1'b1; flush_pc = 32'h00000040; post_allowin = 1'b0;
        step();
        flush = 1'b0;
        repeat (2) step();
        chk("pre_rst_count", 32'(count), 32'd2);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_full", 32'(full), 32'd0);
        step();
        chk("held_rst_count", 32'(count), 32'd0);
        post_allowin = 1'b1;
        resetn = 1'b1;
        step();
        chk("restart_pc0", out_pc, 32'hbfc00000);
        chk("restart_count", 32'(count), 32'd1);
        step();
        chk("restart_pc1", out_pc, 32'hbfc00004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_queue_f.md
PC_QUEUE_F -- requirements
Module: pc_queue_f

Interface
REQ-001 Parameter DEPTH, default 4, meaning queue entries; legal values are 2, 4 or 8.
REQ-002 Parameter AW, default 32, meaning address width.
REQ-003 Parameter RESET_PC, default 32'hbfc00000, meaning first generated PC.
REQ-004 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 Port resetn, input, 1, asynchronous active-low reset.
REQ-006 Port cur_stall, input, 1, holds the output side; no pop while high.
REQ-007 Port post_allowin, input, 1, downstream ready.
REQ-008 Port flush, input, 1, exception redirect; highest priority.
REQ-009 Port flush_pc, input, AW, flush target.
REQ-010 Port br_valid, input, 1, branch resolution is presented this cycle.
REQ-011 Port br_sel, input, 2, target select: INDEX, REG, IMM or PC4.
REQ-012 Port br_taken, input, 1, condition result; qualifies IMM only.
REQ-013 Ports br_pc4, br_imm, br_reg, br_index, input, AW each, candidate targets.
REQ-014 Port out_valid, output, 1, the head entry is presentable.
REQ-015 Port out_pc, output, AW, the head entry PC.
REQ-016 Port count, output, $clog2(DEPTH+1), number of occupied entries.
REQ-017 Port full, output, 1, count==DEPTH.

Function
REQ-018 The generator register gen_pc SHALL hold the next PC to enqueue; on each push gen_pc <= gen_pc + 4, wrapping modulo 2^AW.
REQ-019 Push SHALL occur when no redirect is active and (count<DEPTH or pop occurs in the same cycle).
REQ-020 Pop SHALL occur when out_valid && post_allowin.
REQ-021 out_valid SHALL equal (count!=0) && !cur_stall.
REQ-022 out_pc SHALL show the head entry combinationally, with zero added latency; an entry pushed in cycle N is visible at the output in cycle N+1.
REQ-023 The branch target SHALL resolve as follows:
- INDEX: br_index.
- REG: br_reg.
- IMM with br_taken: br_imm.
- Otherwise: br_pc4.
REQ-024 A branch redirect SHALL be active when br_valid && !flush && the resolved target != br_pc4 path.
- This means sel is INDEX or REG, or sel is IMM with br_taken.
REQ-025 When any redirect is active, on that edge:
- All entries are cleared (count <= 0) and both pointers are reset.
- gen_pc <= target.
- No push and no pop take effect.
REQ-026 If flush and br_valid are both high, flush SHALL win and gen_pc <= flush_pc.
REQ-027 Push and pop in the same cycle SHALL leave count unchanged, including when full or at count==1.
REQ-028 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-029 cur_stall SHALL block pop only; pushes continue until the queue is full.
REQ-030 A non-redirecting br_valid (IMM not taken, or PC4) SHALL have no effect.

Reset
REQ-031 While resetn is low, asynchronously:
- gen_pc = RESET_PC.
- count = 0, both pointers = 0.
- out_valid = 0, full = 0.
REQ-032 The first push after resetn deasserts SHALL occur on the first rising edge and carry RESET_PC.
REQ-033 Reset asserted mid-operation SHALL discard all entries immediately; entry storage contents need no reset.

Structure
REQ-034 The following SHALL live in the shared package/defines:
- The BRANCH_INDEX, BRANCH_REG, BRANCH_IMM and BRANCH_PC4 encodings.
- The RESET_PC default.
REQ-035 Target selection SHALL be one sub-module, br_target_sel, which is combinational.
REQ-036 The sub-module SHALL be instantiated once inside pc_queue_f.
REQ-037 Storage SHALL be a DEPTH x AW register array with binary pointers.

Verification
REQ-038 Reset release with post_allowin=1 and cur_stall=0 -> out_pc sequence bfc00000, bfc00004, bfc00008, with out_valid high from cycle 1.
REQ-039 Fill, DEPTH=4, post_allowin=0 -> count reaches 4 and full=1, gen_pc=bfc00010; post_allowin=1 then pops and pushes together, so count stays 4.
REQ-040 br_valid with sel=IMM, taken=1 and imm=80001000 while count=3 -> next cycle count=0; following outputs 80001000, 80001004.
REQ-041 flush=1 with flush_pc=bfc00380 and br_valid with sel=REG and reg=1234 in the same cycle -> the queue restarts at bfc00380.
REQ-042 cur_stall=1 for 6 cycles -> out_valid=0 and count saturates at DEPTH; on release, the entries drain in order with no loss or duplicates.
REQ-043 resetn pulled low mid-stream with count=2 -> count=0 and out_valid=0 without waiting for a clock edge; restart at bfc00000.
